// File: rtl/score_sequencer.sv
// Game-score controller for a chain of cascaded BCD digit counters.
// Turns scoring events into runs of single-cycle count pulses, shows the
// stored high score on the chain while idle, and updates the high score
// when a game ends.
module score_sequencer #(
  parameter int DIGITS         = 4,
  parameter int POINTS_PER_HIT = 5,
  parameter int REM_W          = 8,
  parameter int HOLD_CYCLES    = 16
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic                hit,
  input  logic                game_over,
  input  logic [4*DIGITS-1:0] score,
  output logic                cnt_clear,
  output logic                cnt_load,
  output logic                cnt_count,
  output logic [4*DIGITS-1:0] highscore,
  output logic                new_high,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    PLAY  = 3'd2,
    DRAIN = 3'd3,
    CMP   = 3'd4,
    SHOW  = 3'd5
  } state_t;

  localparam int TIMER_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};
  localparam logic [REM_W:0] HIT_INC = (REM_W + 1)'(POINTS_PER_HIT);

  state_t               state_q, state_d;
  logic [REM_W-1:0]     rem_q, rem_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [4*DIGITS-1:0]  highscore_d;
  logic                 new_high_d;

  logic                 at_max;
  logic                 pulsing;
  logic [REM_W:0]       rem_sum;
  logic [REM_W-1:0]     rem_sat;

  // The chain sits at 9..9; counting further would wrap it to zero.
  assign at_max = (score == ALL_NINES);

  // Count pulses are decoded from registered state so the chain moves on the same edge.
  assign pulsing   = (state_q == PLAY) || (state_q == DRAIN);
  assign cnt_count = pulsing && (rem_q != '0) && !at_max;
  assign cnt_load  = (state_q == IDLE);
  assign cnt_clear = (state_q == START);
  assign state     = state_q;

  // Pending pulses: add a hit's worth, retire the pulse issued this cycle, clamp at all-ones.
  // The extra top bit holds the overflow; cnt_count implies rem_q != 0, so no underflow.
  assign rem_sum = {1'b0, rem_q} + (hit ? HIT_INC : '0) - {{REM_W{1'b0}}, cnt_count};
  assign rem_sat = rem_sum[REM_W] ? '1 : rem_sum[REM_W-1:0];

  // State register and datapath registers, all reset synchronously by clear.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      timer_q   <= '0;
      highscore <= '0;
      new_high  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      timer_q   <= timer_d;
      highscore <= highscore_d;
      new_high  <= new_high_d;
    end
  end

  // Next-state and next-datapath logic.
  // NOTE: every variable gets a hold-value default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    timer_d     = timer_q;
    highscore_d = highscore;
    new_high_d  = new_high;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = START;
          new_high_d = 1'b0;
          rem_d      = '0;
        end
      end

      START: begin
        state_d = PLAY;
      end

      PLAY: begin
        // At max nothing more can be counted, so pending pulses are dropped.
        rem_d = at_max ? '0 : rem_sat;
        if (game_over) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        if ((rem_q == '0) || at_max) begin
          state_d = CMP;
          rem_d   = '0;
        end else begin
          rem_d = rem_q - {{(REM_W-1){1'b0}}, cnt_count};
        end
      end

      CMP: begin
        // Packed BCD compares in numeric order as a plain unsigned vector.
        if (score > highscore) begin
          highscore_d = score;
          new_high_d  = 1'b1;
        end
        state_d = SHOW;
        timer_d = '0;
      end

      SHOW: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == TIMER_LAST) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_score_sequencer.sv
// Directed bench for score_sequencer: three instances (default, REM_W=3,
// DIGITS=2) share one stimulus stream, each driving its own BCD chain model.
module tb_score_sequencer;

  logic clock = 1'b0;
  logic clear = 1'b1;
  logic start = 1'b0;
  logic hit = 1'b0;
  logic game_over = 1'b0;

  // Default instance
  logic [15:0] score_m = '0;
  logic [15:0] hs_m;
  logic        clr_m, load_m, cnt_m, nh_m;
  logic [2:0]  st_m;
  // REM_W = 3 instance
  logic [15:0] score_s = '0;
  logic [15:0] hs_s;
  logic        clr_s, load_s, cnt_s, nh_s;
  logic [2:0]  st_s;
  // DIGITS = 2 instance
  logic [7:0]  score_d = '0;
  logic [7:0]  hs_d;
  logic        clr_d, load_d, cnt_d, nh_d;
  logic [2:0]  st_d;

  int pulses_m = 0;
  int pulses_s = 0;
  int pulses_d = 0;
  int d_over   = 0;

  int tests    = 0;
  int failures = 0;

  always #5 clock = ~clock;

  score_sequencer u_main (
    .clock(clock), .clear(clear), .start(start), .hit(hit), .game_over(game_over),
    .score(score_m), .cnt_clear(clr_m), .cnt_load(load_m), .cnt_count(cnt_m),
    .highscore(hs_m), .new_high(nh_m), .state(st_m)
  );

  score_sequencer #(.REM_W(3)) u_sat (
    .clock(clock), .clear(clear), .start(start), .hit(hit), .game_over(game_over),
    .score(score_s), .cnt_clear(clr_s), .cnt_load(load_s), .cnt_count(cnt_s),
    .highscore(hs_s), .new_high(nh_s), .state(st_s)
  );

  score_sequencer #(.DIGITS(2)) u_d2 (
    .clock(clock), .clear(clear), .start(start), .hit(hit), .game_over(game_over),
    .score(score_d), .cnt_clear(clr_d), .cnt_load(load_d), .cnt_count(cnt_d),
    .highscore(hs_d), .new_high(nh_d), .state(st_d)
  );

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'h9) begin
          r[4*i +: 4] = 4'h0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'h1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Digit chain models: clear > load > count, plus pulse counters.
  always @(posedge clock) begin
    if (clr_m) score_m <= '0;
    else if (load_m) score_m <= hs_m;
    else if (cnt_m) score_m <= bcd_inc(score_m);
    if (cnt_m) pulses_m <= pulses_m + 1;

    if (clr_s) score_s <= '0;
    else if (load_s) score_s <= hs_s;
    else if (cnt_s) score_s <= bcd_inc(score_s);
    if (cnt_s) pulses_s <= pulses_s + 1;

    if (clr_d) score_d <= '0;
    else if (load_d) score_d <= hs_d;
    else if (cnt_d) score_d <= 8'(bcd_inc({8'h00, score_d}));
    if (cnt_d) pulses_d <= pulses_d + 1;
    if (cnt_d && score_d == 8'h99) d_over <= d_over + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // which: 0 start, 1 hit, 2 game_over; one-cycle pulse.
  task automatic pulse(input int which);
    case (which)
      0: start = 1'b1;
      1: hit = 1'b1;
      default: game_over = 1'b1;
    endcase
    tick();
    start = 1'b0;
    hit = 1'b0;
    game_over = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int bound);
    int n;
    n = 0;
    while (st_m != s && n < bound) begin
      tick();
      n++;
    end
    check(tag, st_m, s);
  endtask

  task automatic begin_game();
    pulse(0);
    tick();
  endtask

  task automatic isolated_hits(input int k);
    int n;
    repeat (k) begin
      pulse(1);
      n = 0;
      while (cnt_m && n < 300) begin
        tick();
        n++;
      end
      check("hit_drain", cnt_m, 0);
    end
  endtask

  // From DRAIN: wait for CMP, then check result, SHOW length and return to IDLE.
  task automatic close_game(input string tag, input logic [15:0] exp_score,
                            input logic [15:0] exp_hs, input logic exp_nh);
    int n;
    wait_state({tag, "_cmp"}, 3'd4, 40);
    check({tag, "_score"}, score_m, exp_score);
    tick();
    check({tag, "_hs"}, hs_m, exp_hs);
    check({tag, "_nh"}, nh_m, exp_nh);
    n = 0;
    while (st_m == 3'd5 && n < 100) begin
      n++;
      tick();
    end
    check({tag, "_show_len"}, n, 16);
    check({tag, "_idle"}, st_m, 3'd0);
  endtask

  task automatic run_game(input string tag, input int hits, input logic [15:0] exp_score,
                          input logic [15:0] exp_hs, input logic exp_nh);
    int base;
    begin_game();
    base = pulses_m;
    isolated_hits(hits);
    pulse(2);
    close_game(tag, exp_score, exp_hs, exp_nh);
    check({tag, "_pulses"}, pulses_m - base, hits * 5);
  endtask

  task automatic hard_clear();
    clear = 1'b1;
    tick();
    tick();
    clear = 1'b0;
  endtask

  initial begin
    int base_m, base_s, base_d, run;

    repeat (3) tick();
    clear = 1'b0;

    // Reset state
    check("rst_state", st_m, 3'd0);
    check("rst_load", load_m, 1);
    check("rst_clear", clr_m, 0);
    check("rst_count", cnt_m, 0);
    check("rst_hs", hs_m, 16'h0000);
    check("rst_nh", nh_m, 0);

    // First game: three isolated hits, new high score
    pulse(0);
    check("start_state", st_m, 3'd1);
    check("start_cnt_clear", clr_m, 1);
    check("start_cnt_load", load_m, 0);
    tick();
    check("play_state", st_m, 3'd2);
    base_m = pulses_m;
    isolated_hits(3);
    pulse(2);
    close_game("g1", 16'h0015, 16'h0015, 1'b1);
    check("g1_pulses", pulses_m - base_m, 15);

    // Clear held two cycles mid-PLAY with pulses pending
    begin_game();
    hit = 1'b1;
    tick();
    tick();
    hit = 1'b0;
    repeat (3) tick();
    check("mid_pending", cnt_m, 1);
    hard_clear();
    check("clr_state", st_m, 3'd0);
    check("clr_load", load_m, 1);
    check("clr_count", cnt_m, 0);
    check("clr_hs", hs_m, 16'h0000);
    check("clr_nh", nh_m, 0);

    // High score 0015, then an equal game and a lower game
    run_game("g2", 3, 16'h0015, 16'h0015, 1'b1);
    run_game("g3", 3, 16'h0015, 16'h0015, 1'b0);

    begin_game();
    base_m = pulses_m;
    base_s = pulses_s;
    hit = 1'b1;
    tick();
    run = int'(cnt_m);
    tick();
    hit = 1'b0;
    while (cnt_m && run < 40) begin
      run++;
      tick();
    end
    check("consec_run", run, 10);
    pulse(2);
    close_game("g4", 16'h0010, 16'h0015, 1'b0);
    check("g4_pulses", pulses_m - base_m, 10);
    check("sat_pulses", pulses_s - base_s, 8);

    // game_over with rem=7, hit and start during DRAIN ignored
    begin_game();
    hit = 1'b1;
    tick();
    tick();
    hit = 1'b0;
    tick();
    tick();
    game_over = 1'b1;
    base_m = pulses_m;
    check("go_pulse", cnt_m, 1);
    tick();
    game_over = 1'b0;
    check("drain_state", st_m, 3'd3);
    hit = 1'b1;
    tick();
    hit = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    close_game("g5", 16'h0010, 16'h0015, 1'b0);
    check("drain_pulses", pulses_m - base_m, 7);

    // Two-digit chain saturates at 99
    hard_clear();
    begin_game();
    base_m = pulses_m;
    base_d = pulses_d;
    isolated_hits(25);
    check("d2_stuck_count", cnt_d, 0);
    pulse(2);
    wait_state("d2_cmp", 3'd4, 40);
    check("d2_state_cmp", st_d, 3'd4);
    check("d2_score", score_d, 8'h99);
    check("d2_pulses", pulses_d - base_d, 99);
    check("d2_over", d_over, 0);
    check("m_score125", score_m, 16'h0125);
    tick();
    check("d2_hs", hs_d, 8'h99);
    check("d2_nh", nh_d, 1);
    check("m_hs125", hs_m, 16'h0125);
    check("m_pulses125", pulses_m - base_m, 125);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
